// File: rtl/stream_rr_flush_ctrl.sv
// stream_rr_flush_ctrl
// Round-robin arbiter feeding one shared two-entry spill stage. A small
// sequencer handles drain (empty the stage normally) and flush (discard the
// stored beats) requests, and acknowledges each with a one-cycle ack_o.
// Optional feature macro: STREAM_RR_FLUSH_CNT_EN adds drop_cnt_o, a saturating
// count of the beats that flushes discarded.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, requesters arbitrated into the stage
// ST_DRAIN | inputs blocked, stored beats leave normally until empty
// ST_FLUSH | single cycle: output hidden, both entries discarded
// ST_ACK   | single cycle: ack_o high, inputs blocked, then back to RUN

module stream_rr_flush_ctrl #(
    parameter int unsigned NumIn = 4,
    parameter type T = logic,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumIn-1:0]              valid_i,
    output logic [NumIn-1:0]              ready_o,
    input  T     [NumIn-1:0]              data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output T                              data_o,
    output logic [IdxWidth-1:0]           idx_o,
    input  logic                          drain_req_i,
    input  logic                          flush_req_i,
    output logic                          ack_o,
    output logic                          busy_o
`ifdef STREAM_RR_FLUSH_CNT_EN
    ,
    output logic [7:0]                    drop_cnt_o
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic [IdxWidth-1:0] LAST_IDX = IdxWidth'(NumIn - 1);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [IdxWidth-1:0] rr_ptr_q;

    // Entry A takes new beats; entry B holds the older beat when A had to
    // move aside while downstream stalled.
    T                    a_data_q;
    T                    b_data_q;
    logic [IdxWidth-1:0] a_idx_q;
    logic [IdxWidth-1:0] b_idx_q;
    logic                a_full_q;
    logic                b_full_q;

    logic                grant_valid;
    logic [IdxWidth-1:0] grant_idx;
    logic                can_accept;
    logic                accept_en;
    logic                in_hs;
    logic                a_drain;
    logic                a_to_b;
    logic                b_drain;
    logic                flush_now;
    logic                stage_empty;

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        int unsigned cand;
        logic [IdxWidth-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NumIn) begin
                cand = cand - NumIn;
            end
            cand_idx = IdxWidth'(cand);
            if (!grant_valid && valid_i[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Readiness comes only from registered occupancy, never from ready_i, so
    // the stage cuts the combinational ready path. A request sampled high
    // blocks input in that very cycle.
    assign can_accept = !a_full_q || !b_full_q;
    assign accept_en  = (state_q == ST_RUN) && !drain_req_i && !flush_req_i && can_accept;
    assign in_hs      = accept_en && grant_valid;

    // One-hot ready towards the granted requester only.
    always_comb begin
        ready_o = '0;
        if (in_hs) begin
            ready_o[grant_idx] = 1'b1;
        end
    end

    assign flush_now   = (state_q == ST_FLUSH);
    assign stage_empty = !a_full_q && !b_full_q;

    assign valid_o = (a_full_q || b_full_q) && !flush_now;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
    assign idx_o   = b_full_q ? b_idx_q  : a_idx_q;

    // A is presented whenever B is empty: it leaves downstream on ready_i,
    // otherwise it moves into B so A is free for the next beat.
    assign a_drain = a_full_q && !b_full_q;
    assign a_to_b  = a_drain && !ready_i;
    assign b_drain = b_full_q && ready_i;

    // Spill-register fill/drain bookkeeping; flush clears both entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
            a_idx_q  <= '0;
            b_idx_q  <= '0;
        end else if (flush_now) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
        end else begin
            if (in_hs) begin
                a_full_q <= 1'b1;
                a_data_q <= data_i[grant_idx];
                a_idx_q  <= grant_idx;
            end else if (a_drain) begin
                a_full_q <= 1'b0;
            end
            if (a_to_b) begin
                b_full_q <= 1'b1;
                b_data_q <= a_data_q;
                b_idx_q  <= a_idx_q;
            end else if (b_drain) begin
                b_full_q <= 1'b0;
            end
        end
    end

    // Advance the pointer past the winner, but only when a beat is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (in_hs) begin
            rr_ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Sequencer next state; flush takes priority over drain everywhere.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                end else if (drain_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                end else if (stage_empty) begin
                    state_d = ST_ACK;
                end
            end
            ST_FLUSH: state_d = ST_ACK;
            ST_ACK:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign ack_o  = (state_q == ST_ACK);
    assign busy_o = (state_q != ST_RUN);

`ifdef STREAM_RR_FLUSH_CNT_EN
    logic [7:0] drop_cnt_q;
    logic [1:0] drop_add;
    logic [8:0] drop_sum;

    assign drop_add   = {1'b0, a_full_q} + {1'b0, b_full_q};
    assign drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_add};
    assign drop_cnt_o = drop_cnt_q;

    // Count beats thrown away by a flush, clamping at the top.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (flush_now) begin
            drop_cnt_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        end
    end
`endif

endmodule

// File: doc/stream_rr_flush_ctrl.md
Name: stream_rr_flush_ctrl

Overview:
- Shares one path-cutting two-entry output stage between NumIn ready/valid requesters using round-robin arbitration.
- Output stage has flushable spill-register semantics; stored entries carry the source index.
- A small sequencer serves software/pipeline-control requests: drain (empty normally) or flush (discard stored beats).
- Sits in front of shared downstream resources such as a single-port interconnect slot or a shared functional unit.

Parameters:
- NumIn, 4, number of requesters; legal values are >= 2.
- T, logic, payload type carried per beat.
- IdxWidth, max(1,$clog2(NumIn)), width of the source index; derived, never overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  NumIn  per-requester valid.
- ready_o  out  NumIn  per-requester ready; at most one bit high per cycle.
- data_i  in  NumIn x $bits(T)  per-requester payload.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.
- data_o  out  $bits(T)  output payload.
- idx_o  out  IdxWidth  source requester of data_o.
- drain_req_i  in  1  level request: stop accepting input, let stored beats leave, then acknowledge.
- flush_req_i  in  1  level request: stop accepting input, discard stored beats, then acknowledge.
- ack_o  out  1  one-cycle acknowledge for drain or flush.
- busy_o  out  1  high whenever state != RUN.

Behaviour:
- Reset: all outputs 0, both entries empty, state RUN, RR pointer 0.
- Synchronous active-high reset wins over every other event, including mid-flush or mid-drain.
- Storage: entries A and B, each holding {payload, idx}.
  - Input accept = store into A.
  - When A drains while downstream is not ready, A moves to B.
  - Output shows B when B is full, else A.
  - valid_o = A_full | B_full, except in FLUSH.
  - Stage ready (can_accept) = !A_full | !B_full, taken from registers only; no combinational path from ready_i to ready_o.
- Latency: input handshake in cycle n gives valid_o in cycle n+1. Sustained throughput is 1 beat/cycle.
- Arbitration: grant goes to the first valid_i at or after the RR pointer, wrapping from NumIn-1 to 0.
  - ready_o[g] = (state==RUN) & can_accept & valid_i[g]; every other ready_o bit is 0.
  - Pointer becomes g+1 (mod NumIn) only on an input handshake. Grant may move between non-accepted cycles.
- Handshakes: requester valid/data stay stable until ready. Downstream may hold ready_i low indefinitely without loss.
- FSM:
  - RUN:
    - flush_req_i -> FLUSH (flush wins if both requests are high).
    - else drain_req_i -> DRAIN.
    - No input is accepted in the cycle a request is sampled high.
  - DRAIN:
    - Inputs blocked; output handshakes continue.
    - Both entries empty -> ACK. This includes the case where they are already empty on entry, giving ACK the next cycle.
    - flush_req_i rising during DRAIN -> FLUSH.
  - FLUSH: lasts exactly one cycle.
    - valid_o forced 0 and inputs blocked.
    - Both entries are cleared at the end of the cycle; a flush on an empty stage is legal.
    - Next state is ACK.
  - ACK: ack_o=1 for one cycle, inputs blocked, then -> RUN.
    - The requester drops its request on ack.
    - A request still high when back in RUN starts a new operation.
- Simultaneous events: an input handshake and an output handshake in the same cycle are both honoured. Entry contents follow spill-register fill/drain rules.

Optional Feature:
- Macro: STREAM_RR_FLUSH_CNT_EN.
- Defined: adds output drop_cnt_o (8 bits).
  - Saturating count of valid entries discarded by FLUSH; adds 0, 1 or 2 per flush, clamps at 255.
  - Reset to 0 by rst_i only.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Round-robin: all 4 valid_i high with ready_i=1 -> idx_o sequence 0,1,2,3,0; one beat per cycle after 1-cycle latency.
- Backpressure: ready_i=0 for 5 cycles while requesters 1 and 2 are valid -> exactly 2 beats accepted. After ready_i=1, output is req1 then req2 with data intact; no duplicates.
- Drain: 2 beats stored, drain_req_i=1, ready_i=1 -> both beats leave, ack_o pulses 1 cycle later, ready_o stays 0 throughout, busy_o falls with return to RUN.
- Flush: 2 beats stored, ready_i=0, flush_req_i=1 -> valid_o=0 in FLUSH, ack_o next cycle, stage empty. With STREAM_RR_FLUSH_CNT_EN, drop_cnt_o=2.
- Priority: drain_req_i and flush_req_i rise together -> FLUSH path taken. Flush raised mid-DRAIN -> escalates, a single ack_o.
- Reset mid-operation: rst_i=1 during DRAIN with 1 beat stored -> next cycle state RUN, valid_o=0, ack_o=0, pointer 0, first grant to requester 0.
